// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: button indices, one-hot button codes and the
// per-button conditioner state type.
package alarm_clock_pkg;

    localparam int NUM_BTN = 5;

    localparam int BTN_C = 0;
    localparam int BTN_R = 1;
    localparam int BTN_L = 2;
    localparam int BTN_U = 3;
    localparam int BTN_D = 4;

    localparam logic [NUM_BTN-1:0] BTNC_CODE = 5'b00001;
    localparam logic [NUM_BTN-1:0] BTNR_CODE = 5'b00010;
    localparam logic [NUM_BTN-1:0] BTNL_CODE = 5'b00100;
    localparam logic [NUM_BTN-1:0] BTNU_CODE = 5'b01000;
    localparam logic [NUM_BTN-1:0] BTND_CODE = 5'b10000;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        REL_DB
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, tick-based debounce and press FSM.
// Hold-to-repeat is built only when BTN_CONDITIONER_REPEAT_EN is defined.
module btn_channel
    import alarm_clock_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
`ifdef BTN_CONDITIONER_REPEAT_EN
    ,
    parameter bit REPEAT_EN           = 1'b0,
    parameter int REPEAT_DELAY_TICKS  = 100,
    parameter int REPEAT_PERIOD_TICKS = 20
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic raw_i,
    output logic event_o,
    output logic level_o
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               DB_SINGLE = (DEBOUNCE_TICKS == 1);

`ifdef BTN_CONDITIONER_REPEAT_EN
    localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY_TICKS, REPEAT_PERIOD_TICKS) + 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD_TICKS - 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
`endif

    logic             sync1_q, sync2_q;
    logic [1:0]       fill_q;
    logic             armed_q, armed_d;
    logic             level_q, level_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, start_rel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= '0;
            armed_q <= 1'b0;
            level_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef BTN_CONDITIONER_REPEAT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values;
            // blocking would collapse the two synchroniser stages into one.
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_d;
            level_q <= level_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef BTN_CONDITIONER_REPEAT_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        armed_d   = armed_q;
        event_o   = 1'b0;
        accept    = 1'b0;
        start_rel = 1'b0;
`ifdef BTN_CONDITIONER_REPEAT_EN
        rcnt_d    = rcnt_q;
`endif

        if (tick_i) begin
            // A press already down across reset stays ignored until a genuine
            // release has been seen through the refilled synchroniser.
            if (fill_q[1] && !sync2_q) armed_d = 1'b1;

            case (state_q)
                IDLE: begin
                    if (sync2_q && armed_q) begin
                        if (DB_SINGLE) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!sync2_q)                state_d = IDLE;
                    else if (cnt_q == DB_LAST)   accept  = 1'b1;
                    else if (cnt_q != '1)        cnt_d   = cnt_q + 1'b1;
                end
                HELD: begin
                    if (!sync2_q) begin
                        start_rel = 1'b1;
`ifdef BTN_CONDITIONER_REPEAT_EN
                    end else if (REPEAT_EN) begin
                        if (rcnt_q == DELAY_LAST) begin
                            event_o = 1'b1;
                            rcnt_d  = '0;
                            state_d = REPEAT;
                        end else if (rcnt_q != '1) begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
`endif
                    end
                end
`ifdef BTN_CONDITIONER_REPEAT_EN
                REPEAT: begin
                    if (!sync2_q) begin
                        start_rel = 1'b1;
                    end else if (rcnt_q == PERIOD_LAST) begin
                        event_o = 1'b1;
                        rcnt_d  = '0;
                    end else if (rcnt_q != '1) begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
`endif
                REL_DB: begin
                    if (sync2_q) begin
                        state_d = HELD;
`ifdef BTN_CONDITIONER_REPEAT_EN
                        rcnt_d  = '0;
`endif
                    end else if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (accept) begin
                state_d = HELD;
                level_d = 1'b1;
                event_o = 1'b1;
`ifdef BTN_CONDITIONER_REPEAT_EN
                rcnt_d  = '0;
`endif
            end

            // The 0 sample that leaves HELD/REPEAT is the first of the release run.
            if (start_rel) begin
                if (DB_SINGLE) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else begin
                    state_d = REL_DB;
                    cnt_d   = CNT_ONE;
                end
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Five-button conditioner: per-button channels plus lowest-index arbitration
// into a registered one-hot pulse. Auto-repeat needs BTN_CONDITIONER_REPEAT_EN.
module button_conditioner
    import alarm_clock_pkg::*;
#(
    parameter int DEBOUNCE_TICKS      = 4,
    parameter int REPEAT_DELAY_TICKS  = 100,
    parameter int REPEAT_PERIOD_TICKS = 20,
    parameter int REPEAT_MASK         = 5'b11000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               btn_any
);

    if (DEBOUNCE_TICKS < 1 || REPEAT_DELAY_TICKS < 1 || REPEAT_PERIOD_TICKS < 1) begin : g_bad_ticks
        $fatal(1, "button_conditioner: tick parameters must be at least 1");
    end

    if (REPEAT_MASK < 0 || REPEAT_MASK >= (1 << NUM_BTN)) begin : g_bad_mask
        $fatal(1, "button_conditioner: REPEAT_MASK names a button that does not exist");
    end

    logic [NUM_BTN-1:0] req;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic               any_q, any_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_TICKS     (DEBOUNCE_TICKS)
`ifdef BTN_CONDITIONER_REPEAT_EN
            ,
            .REPEAT_EN          (REPEAT_MASK[i]),
            .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
            .REPEAT_PERIOD_TICKS(REPEAT_PERIOD_TICKS)
`endif
        ) u_channel (
            .clk    (clk),
            .rst    (rst),
            .tick_i (sample_tick),
            .raw_i  (btn_raw[i]),
            .event_o(req[i]),
            .level_o(btn_level[i])
        );
    end

    always_comb begin
        // x & -x isolates the lowest set bit; the other requests are dropped.
        grant   = req & (~req + 1'b1);
        pulse_d = any_q ? '0 : grant;
        any_d   = |pulse_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pulse_q <= '0;
            any_q   <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            any_q   <= any_d;
        end
    end

    assign btn_pulse = pulse_q;
    assign btn_any   = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters; the U-hold
// expectation follows whether BTN_CONDITIONER_REPEAT_EN is defined.
`timescale 1ns/1ps
module tb_button_conditioner;
    import alarm_clock_pkg::*;

`ifdef BTN_CONDITIONER_REPEAT_EN
    localparam int EXP_U_PULSES   = 4;
    localparam int EXP_U_LAST_OFS = 140;
`else
    localparam int EXP_U_PULSES   = 1;
    localparam int EXP_U_LAST_OFS = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_tick;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [NUM_BTN-1:0] btn_level;
    logic               btn_any;

    button_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .btn_raw    (btn_raw),
        .btn_pulse  (btn_pulse),
        .btn_level  (btn_level),
        .btn_any    (btn_any)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    bit mon_en   = 1'b0;

    int                 pcnt [NUM_BTN]      = '{default: 0};
    int                 last_tick [NUM_BTN] = '{default: -1};
    int                 total_pulses        = 0;
    int                 consec              = 0;
    int                 nonhot              = 0;
    int                 any_bad             = 0;
    logic [NUM_BTN-1:0] last_code           = '0;
    logic [NUM_BTN-1:0] prev_pulse          = '0;

    // Pulse monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if ($isunknown(btn_pulse) || !$onehot0(btn_pulse)) nonhot++;
            if (btn_any !== (|btn_pulse)) any_bad++;
            if (btn_pulse != '0 && prev_pulse != '0) consec++;
            if (btn_pulse != '0) begin
                total_pulses++;
                last_code = btn_pulse;
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (btn_pulse[i]) begin
                        pcnt[i]++;
                        last_tick[i] = tick_cnt;
                    end
                end
            end
            prev_pulse = btn_pulse;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One tick: two idle clocks so the synchroniser has settled, then a
    // one-clock strobe; returns just after the negedge following it.
    task automatic do_tick();
        repeat (2) @(negedge clk);
        tick_cnt++;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    int base, base_tot, rise;

    initial begin
        rst         = 1'b0;
        sample_tick = 1'b0;
        btn_raw     = 5'b11111;

        // Reset with every button down.
        repeat (3) @(negedge clk);
        #1;
        check("reset_pulse", 32'(btn_pulse), 32'h0);
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_any", 32'(btn_any), 32'h0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Presses held through reset are dropped.
        ticks(8);
        check("held_thru_reset_pulses", 32'(total_pulses), 32'd0);
        check("held_thru_reset_level", 32'(btn_level), 32'h0);
        btn_raw = 5'b00000;
        ticks(2);

        // Bounce on C, then a clean hold.
        base = pcnt[BTN_C];
        btn_raw = 5'b00001; do_tick();
        btn_raw = 5'b00000; do_tick();
        btn_raw = 5'b00001; do_tick();
        btn_raw = 5'b00000; do_tick();
        btn_raw = 5'b00001;
        rise = tick_cnt + 1;
        ticks(3);
        check("bounce_no_early_pulse", 32'(pcnt[BTN_C] - base), 32'd0);
        do_tick();
        check("bounce_one_pulse", 32'(pcnt[BTN_C] - base), 32'd1);
        check("bounce_pulse_tick", 32'(last_tick[BTN_C]), 32'(rise + 3));
        check("bounce_code", 32'(last_code), 32'(BTNC_CODE));
        check("bounce_level", 32'(btn_level), 32'(BTNC_CODE));

        // Release glitch of two ticks on C.
        base = pcnt[BTN_C];
        btn_raw = 5'b00000;
        ticks(2);
        check("glitch_level_kept", 32'(btn_level[BTN_C]), 32'd1);
        btn_raw = 5'b00001;
        ticks(4);
        check("glitch_no_pulse", 32'(pcnt[BTN_C] - base), 32'd0);
        check("glitch_level", 32'(btn_level[BTN_C]), 32'd1);

        // Real release: level drops on the fourth zero sample.
        btn_raw = 5'b00000;
        ticks(3);
        check("release_level_3", 32'(btn_level[BTN_C]), 32'd1);
        do_tick();
        check("release_level_4", 32'(btn_level[BTN_C]), 32'd0);
        ticks(2);

        // Hold U for 160 ticks.
        base     = pcnt[BTN_U];
        base_tot = total_pulses;
        btn_raw  = 5'b01000;
        rise     = tick_cnt + 1;
        ticks(160);
        check("u_hold_pulses", 32'(pcnt[BTN_U] - base), 32'(EXP_U_PULSES));
        check("u_hold_last_tick", 32'(last_tick[BTN_U]), 32'(rise + 3 + EXP_U_LAST_OFS));
        check("u_hold_only_u", 32'(total_pulses - base_tot), 32'(EXP_U_PULSES));
        btn_raw = 5'b00000;
        ticks(6);

        // Hold C for 160 ticks: C is not repeat-eligible.
        base    = pcnt[BTN_C];
        btn_raw = 5'b00001;
        rise    = tick_cnt + 1;
        ticks(160);
        check("c_hold_pulses", 32'(pcnt[BTN_C] - base), 32'd1);
        check("c_hold_tick", 32'(last_tick[BTN_C]), 32'(rise + 3));
        btn_raw = 5'b00000;
        ticks(6);

        // R and D pressed on the same clock: R wins, D is dropped.
        base     = pcnt[BTN_R];
        base_tot = pcnt[BTN_D];
        btn_raw  = 5'b10010;
        ticks(4);
        check("simul_r_pulse", 32'(pcnt[BTN_R] - base), 32'd1);
        check("simul_d_dropped", 32'(pcnt[BTN_D] - base_tot), 32'd0);
        check("simul_code", 32'(last_code), 32'(BTNR_CODE));
        check("simul_level", 32'(btn_level), 32'h12);
        btn_raw = 5'b00000;
        ticks(6);
        check("simul_released", 32'(btn_level), 32'h0);

        // Reset during PRESS_DB with R still held.
        base    = pcnt[BTN_R];
        btn_raw = 5'b00010;
        ticks(2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        ticks(8);
        check("midreset_no_pulse", 32'(pcnt[BTN_R] - base), 32'd0);
        check("midreset_level", 32'(btn_level[BTN_R]), 32'd0);
        btn_raw = 5'b00000;
        ticks(2);
        btn_raw = 5'b00010;
        ticks(3);
        check("midreset_repress_early", 32'(pcnt[BTN_R] - base), 32'd0);
        do_tick();
        check("midreset_repress_pulse", 32'(pcnt[BTN_R] - base), 32'd1);
        btn_raw = 5'b00000;
        ticks(6);

        // No ticks for 1000 clocks with L down.
        base    = pcnt[BTN_L];
        btn_raw = 5'b00100;
        repeat (1000) @(negedge clk);
        #1;
        check("freeze_no_pulse", 32'(pcnt[BTN_L] - base), 32'd0);
        check("freeze_level", 32'(btn_level[BTN_L]), 32'd0);
        ticks(4);
        check("freeze_then_pulse", 32'(pcnt[BTN_L] - base), 32'd1);
        check("freeze_code", 32'(last_code), 32'(BTNL_CODE));
        btn_raw = 5'b00000;
        ticks(6);

        // Whole-run output properties.
        check("final_level", 32'(btn_level), 32'h0);
        check("pulse_onehot0", 32'(nonhot), 32'd0);
        check("pulse_not_consecutive", 32'(consec), 32'd0);
        check("any_matches_pulse", 32'(any_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage of the alarm-clock control FSM: converts the five raw board buttons (C, R, L, U, D) into clean, single-cycle, one-hot press events.
- Per button: 2-FF synchroniser, then tick-based debounce, then a press FSM. U/D also get hold-to-repeat for fast time/alarm adjustment.
- The output bus is one-hot or zero. It is compared directly against the constants 5'b00001, 5'b00010, 5'b00100, 5'b01000 and 5'b10000 by the control FSM.

Parameters:
- DEBOUNCE_TICKS, 4: number of consecutive sample_tick samples at a new level required to accept it.
- REPEAT_DELAY_TICKS, 100: number of ticks a U/D button must be held after acceptance before the first repeat event.
- REPEAT_PERIOD_TICKS, 20: number of ticks between subsequent repeat events.
- REPEAT_MASK, 5'b11000: buttons eligible for auto-repeat (bit 0 = C, 1 = R, 2 = L, 3 = U, 4 = D).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-low reset.
- sample_tick, input, 1: one-clk-wide sampling strobe (e.g. 200 Hz from the clock divider).
- btn_raw, input, 5: asynchronous button levels, active-high.
- btn_pulse, output, 5: registered one-hot press/repeat event, one clk wide; otherwise 0.
- btn_level, output, 5: debounced button levels.
- btn_any, output, 1: equals |btn_pulse, registered in the same cycle as btn_pulse.

Behaviour:
- Reset:
  - Applied on the clk edge where rst==0.
  - Clears btn_pulse, btn_level, btn_any, both synchroniser stages, all counters and all FSMs (to IDLE).
  - A reset mid-press drops the press; the button must be released and re-pressed to produce an event.
- Synchroniser:
  - btn_raw passes through 2 flops every clk, independent of sample_tick.
- Per-button FSM; it advances only on clk cycles with sample_tick==1:
  - IDLE: if sync==1, load cnt=1 and go to PRESS_DB.
  - PRESS_DB:
    - sync==0: go to IDLE.
    - sync==1 and cnt==DEBOUNCE_TICKS-1: go to HELD, set level=1, raise the event, clear rcnt.
    - Otherwise cnt++.
  - HELD:
    - sync==0: load cnt=1 and go to REL_DB.
    - Else, if the button is in REPEAT_MASK: rcnt++. When rcnt reaches REPEAT_DELAY_TICKS-1, raise the event, clear rcnt and go to REPEAT.
  - REPEAT:
    - sync==0: go to REL_DB.
    - Else rcnt++. When rcnt reaches REPEAT_PERIOD_TICKS-1, raise the event and clear rcnt.
  - REL_DB:
    - sync==1: return to HELD (no event, rcnt cleared).
    - After DEBOUNCE_TICKS consecutive 0 samples: go to IDLE, set level=0.
- Output arbitration:
  - The raised events of all buttons in one tick form a 5-bit request vector.
  - btn_pulse is registered to the lowest-index set bit only. Losers are dropped, not queued.
  - btn_pulse is driven on the clk after the tick; it is held for exactly one clk and is never asserted two consecutive clks.
- Latency: press-to-pulse = DEBOUNCE_TICKS ticks + 2 clk (synchroniser) + 1 clk (output register).
- Counters:
  - Width is $clog2(max(param)+1).
  - Counters saturate; they never wrap.
  - Parameters with value < 1 are illegal; an elaboration-time check is required.
- No tick: sample_tick held 0 freezes all FSMs and counters. The synchroniser keeps running.

Optional Feature:
- Macro: BTN_CONDITIONER_REPEAT_EN.
- Defined: auto-repeat as above. The REPEAT state and rcnt are present.
- Undefined: REPEAT_MASK is ignored, rcnt and the REPEAT state are removed, and HELD only waits for release. Exactly one event per press regardless of hold time.

Decomposition:
- Shared package alarm_clock_pkg holds:
  - Button index constants: BTN_C=0, BTN_R=1, BTN_L=2, BTN_U=3, BTN_D=4.
  - One-hot codes: BTNC_CODE=5'b00001 … BTND_CODE=5'b10000.
  - The per-button FSM state typedef {IDLE, PRESS_DB, HELD, REPEAT, REL_DB}.
- One sub-module, btn_channel: synchroniser, debounce and repeat for a single button. It is instantiated 5× via generate with per-bit repeat enable = REPEAT_MASK[i].
- Arbitration and the output register stay in the top.

Test Plan:
- Reset: hold rst=0 for 3 clk with btn_raw=5'b11111 → btn_pulse, btn_level and btn_any all 0. After release, the first pulse appears no earlier than 4 ticks + 3 clk.
- Bounce: toggle btn_raw[0] 1,0,1,0 on successive ticks, then hold 1 → exactly one btn_pulse=5'b00001, emitted DEBOUNCE_TICKS ticks after the final rising edge; btn_level[0]=1.
- Release glitch: hold C, drop it for 2 ticks, then re-assert → no second pulse, btn_level[0] stays 1.
- Auto-repeat: hold btn_raw[3] for 160 ticks → pulses 5'b01000 at accept, accept+100, accept+120 and accept+140 (4 total).
- Auto-repeat: hold btn_raw[0] for 160 ticks → 1 pulse only.
- Without BTN_CONDITIONER_REPEAT_EN, hold U for 160 ticks → 1 pulse.
- Simultaneous: assert btn_raw=5'b10010 on the same clk → single btn_pulse=5'b00010, D's event dropped, btn_level=5'b10010.
- Reset mid-operation: press R, assert rst=0 for 1 clk during PRESS_DB, keep R held → no pulse until R is released and re-pressed.
- Tick freeze: hold sample_tick=0 for 1000 clk with L pressed → no pulse. A subsequent 4 ticks → 5'b00100.
